stack_core_p: RTL and testbench

//  Parametrised stack-machine execution core: fetches instructions from ROM and keeps an

---
 rtl/stack_core_p.sv | 191 +++++++++++++++++++
 tb/tb_stack_core_p.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_core_p.sv
// rtl/stack_core_p.sv - parametrised stack-machine core: ROM instruction fetch, RAM operand stack
module stack_core_p #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int STACK_BASE  = 0,
   parameter int STACK_DEPTH = 256,
   parameter int ROM_LAT     = 2,
   parameter int RAM_LAT     = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_q,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] sp_out,
   output logic              halted,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int MAX_LAT = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CW-1:0]     ROM_LAST = CW'(ROM_LAT - 1);
   localparam logic [CW-1:0]     RAM_LAST = CW'(RAM_LAT - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] A1       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A2       = ADDR_W'(2);
   localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(STACK_DEPTH);
   localparam logic [ADDR_W:0]   N1       = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   N2       = (ADDR_W+1)'(2);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_OPERAND, S_READ_TOS, S_READ_NOS, S_EXEC, S_HALT, S_ERROR
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP, OP_IMM, OP_DUP, OP_DROP, OP_HALT, OP_JMP, OP_JZ,
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BAD
   } op_t;

   state_t            state, state_n;
   op_t               op_r, op_n, dec_op;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] pc, pc_n, sp, sp_n, opnd_r;
   logic [DATA_W-1:0] tos_r, alu_r;
   logic [1:0]        err_n;
   logic [ADDR_W:0]   depth;
   logic              is_alu, waiting;

   assign depth    = {1'b0, sp} - {1'b0, BASE};
   assign is_alu   = op_r inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
   assign waiting  = state inside {S_FETCH, S_OPERAND, S_READ_TOS, S_READ_NOS};
   assign pc_out   = pc;
   assign sp_out   = sp;
   assign halted   = (state == S_HALT);
   assign error    = (state == S_ERROR);

   // Opcodes are full-word matches; upper bits of a wide word must be zero.
   always_comb begin
      case (rom_q)
         DATA_W'(16'h0000): dec_op = OP_NOP;
         DATA_W'(16'h0002): dec_op = OP_IMM;
         DATA_W'(16'h0003): dec_op = OP_DUP;
         DATA_W'(16'h0004): dec_op = OP_DROP;
         DATA_W'(16'h00FF): dec_op = OP_HALT;
         DATA_W'(16'h1000): dec_op = OP_JMP;
         DATA_W'(16'h1001): dec_op = OP_JZ;
         DATA_W'(16'h2000): dec_op = OP_ADD;
         DATA_W'(16'h2001): dec_op = OP_SUB;
         DATA_W'(16'h2002): dec_op = OP_AND;
         DATA_W'(16'h2003): dec_op = OP_OR;
         DATA_W'(16'h2004): dec_op = OP_XOR;
         default:           dec_op = OP_BAD;
      endcase
   end

   // In EXEC of an ALU op, ram_q carries NOS and tos_r was captured during READ_NOS.
   always_comb begin
      case (op_r)
         OP_SUB:  alu_r = tos_r - ram_q;
         OP_AND:  alu_r = tos_r & ram_q;
         OP_OR:   alu_r = tos_r | ram_q;
         OP_XOR:  alu_r = tos_r ^ ram_q;
         default: alu_r = tos_r + ram_q;
      endcase
   end

   always_comb begin
      state_n  = state;
      op_n     = op_r;
      pc_n     = pc;
      sp_n     = sp;
      err_n    = err_code;
      rom_addr = pc;
      ram_addr = '0;
      ram_wren = 1'b0;
      ram_data = '0;
      case (state)
         S_FETCH: if (cnt == ROM_LAST) state_n = S_DECODE;
         S_DECODE: begin
            op_n = dec_op;
            if (dec_op == OP_BAD) begin
               state_n = S_ERROR;
               err_n   = 2'd1;
            end else if ((dec_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR} && depth < N2) ||
                         (dec_op inside {OP_DUP, OP_DROP, OP_JZ} && depth < N1)) begin
               state_n = S_ERROR;
               err_n   = 2'd3;
            end else if (dec_op inside {OP_IMM, OP_DUP} && depth == DEPTH) begin
               state_n = S_ERROR;
               err_n   = 2'd2;
            end else begin
               case (dec_op)
                  OP_NOP:  begin pc_n = pc + A1; state_n = S_FETCH; end
                  OP_DROP: begin pc_n = pc + A1; sp_n = sp - A1; state_n = S_FETCH; end
                  OP_HALT: state_n = S_HALT;
                  OP_IMM, OP_JMP, OP_JZ: state_n = S_OPERAND;
                  default: state_n = S_READ_TOS;
               endcase
            end
         end
         S_OPERAND: begin
            rom_addr = pc + A1;
            if (cnt == ROM_LAST) state_n = (op_r == OP_JZ) ? S_READ_TOS : S_EXEC;
         end
         S_READ_TOS: begin
            ram_addr = sp - A1;
            if (cnt == RAM_LAST) state_n = is_alu ? S_READ_NOS : S_EXEC;
         end
         S_READ_NOS: begin
            ram_addr = sp - A2;
            if (cnt == RAM_LAST) state_n = S_EXEC;
         end
         S_EXEC: begin
            state_n  = S_FETCH;
            ram_addr = sp - A1;
            case (op_r)
               OP_IMM: begin
                  ram_wren = 1'b1; ram_addr = sp; ram_data = rom_q;
                  sp_n = sp + A1; pc_n = pc + A2;
               end
               OP_DUP: begin
                  ram_wren = 1'b1; ram_addr = sp; ram_data = ram_q;
                  sp_n = sp + A1; pc_n = pc + A1;
               end
               OP_JMP: pc_n = rom_q[ADDR_W-1:0];
               OP_JZ: begin
                  sp_n = sp - A1;
                  pc_n = (ram_q == '0) ? opnd_r : pc + A2;
               end
               default: begin
                  ram_wren = 1'b1; ram_addr = sp - A2; ram_data = alu_r;
                  sp_n = sp - A1; pc_n = pc + A1;
               end
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         op_r     <= OP_NOP;
         cnt      <= '0;
         pc       <= '0;
         sp       <= BASE;
         opnd_r   <= '0;
         tos_r    <= '0;
         result   <= '0;
         err_code <= 2'd0;
      end else begin
         state    <= state_n;
         op_r     <= op_n;
         pc       <= pc_n;
         sp       <= sp_n;
         err_code <= err_n;
         cnt      <= (waiting && state_n == state) ? cnt + CW'(1) : '0;
         if (ram_wren) result <= ram_data;
         // Read data lags its address by the latency, so it is captured in the following state.
         if (state == S_READ_NOS && cnt == '0) tos_r <= ram_q;
         if (state == S_READ_TOS && cnt == '0 && op_r == OP_JZ) opnd_r <= rom_q[ADDR_W-1:0];
      end
   end

endmodule

// File: tb/tb_stack_core_p.sv
// tb/tb_stack_core_p.sv - self-checking bench for stack_core_p against an instruction-level model
module tb_stack_core_p;

   localparam int OP_NOP = 'h0000, OP_IMM = 'h0002, OP_DUP = 'h0003, OP_DROP = 'h0004;
   localparam int OP_HALT = 'h00FF, OP_JMP = 'h1000, OP_JZ = 'h1001, OP_ADD = 'h2000;
   localparam int OP_SUB = 'h2001, OP_AND = 'h2002, OP_OR = 'h2003, OP_XOR = 'h2004;
   localparam int OP_ILL = 'h1234;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a = 1'b1, rst_b = 1'b1;

   logic [15:0] rom_addr_a, ram_addr_a, pc_a, sp_a;
   logic [15:0] rom_q_a, ram_q_a, ram_data_a, result_a;
   logic        ram_wren_a, halted_a, error_a;
   logic [1:0]  err_code_a;
   logic [15:0] rom_addr_b, ram_addr_b, pc_b, sp_b;
   logic [31:0] rom_q_b, ram_q_b, ram_data_b, result_b;
   logic        ram_wren_b, halted_b, error_b;
   logic [1:0]  err_code_b;

   stack_core_p #(.DATA_W(16), .ADDR_W(16), .STACK_BASE(0), .STACK_DEPTH(256),
                  .ROM_LAT(2), .RAM_LAT(2)) dut_a (
      .clock(clk), .reset(rst_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
      .ram_addr(ram_addr_a), .ram_q(ram_q_a), .ram_wren(ram_wren_a), .ram_data(ram_data_a),
      .result(result_a), .pc_out(pc_a), .sp_out(sp_a), .halted(halted_a),
      .error(error_a), .err_code(err_code_a));

   stack_core_p #(.DATA_W(32), .ADDR_W(16), .STACK_BASE(4), .STACK_DEPTH(2),
                  .ROM_LAT(1), .RAM_LAT(1)) dut_b (
      .clock(clk), .reset(rst_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
      .ram_addr(ram_addr_b), .ram_q(ram_q_b), .ram_wren(ram_wren_b), .ram_data(ram_data_b),
      .result(result_b), .pc_out(pc_b), .sp_out(sp_b), .halted(halted_b),
      .error(error_b), .err_code(err_code_b));

   // Memory models: latency-deep read pipelines, writes logged for comparison.
   logic [15:0] rom_a [256];
   logic [15:0] ram_a [256];
   logic [15:0] rom_a_p, ram_a_p;
   logic [31:0] rom_b [256];
   logic [31:0] ram_b [256];
   logic [15:0] wa_a [1024];
   logic [15:0] wd_a [1024];
   logic [15:0] wa_b [1024];
   logic [31:0] wd_b [1024];
   int wr_idx_a = 0, wr_idx_b = 0;

   always @(posedge clk) begin
      rom_a_p <= rom_a[rom_addr_a[7:0]];
      rom_q_a <= rom_a_p;
      ram_a_p <= ram_a[ram_addr_a[7:0]];
      ram_q_a <= ram_a_p;
      if (ram_wren_a) begin
         ram_a[ram_addr_a[7:0]] <= ram_data_a;
         wa_a[wr_idx_a[9:0]] <= ram_addr_a;
         wd_a[wr_idx_a[9:0]] <= ram_data_a;
         wr_idx_a <= wr_idx_a + 1;
      end
      rom_q_b <= rom_b[rom_addr_b[7:0]];
      ram_q_b <= ram_b[ram_addr_b[7:0]];
      if (ram_wren_b) begin
         ram_b[ram_addr_b[7:0]] <= ram_data_b;
         wa_b[wr_idx_b[9:0]] <= ram_addr_b;
         wd_b[wr_idx_b[9:0]] <= ram_data_b;
         wr_idx_b <= wr_idx_b + 1;
      end
   end

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] prog [256];
   int          m_pc, m_sp, m_code, m_cycles, m_nwr;
   bit          m_halt, m_err;
   logic [31:0] m_result;
   logic [31:0] m_wa [64];
   logic [31:0] m_wd [64];

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = OP_ILL;
   endtask

   // Executes prog instruction by instruction; cycles are summed from the per-state latencies.
   task automatic model_run(input int dw, input int depth, input int base, input int lr, input int lm);
      logic [31:0] mask, w, opnd, t, s, r;
      logic [31:0] stk[$];
      int pc, n;
      mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
      pc = 0; m_cycles = 0; m_nwr = 0; m_result = 0; m_halt = 0; m_err = 0; m_code = 0;
      for (int steps = 0; steps < 500 && !m_halt && !m_err; steps++) begin
         w = prog[pc % 256];
         opnd = prog[((pc + 1) % 65536) % 256] & mask;
         n = stk.size();
         m_cycles += lr + 1;
         case (w)
            OP_NOP:  pc = pc + 1;
            OP_HALT: m_halt = 1;
            OP_DROP: if (n < 1) begin m_err = 1; m_code = 3; end
                     else begin void'(stk.pop_back()); pc = pc + 1; end
            OP_IMM, OP_DUP: begin
               if (w == OP_DUP && n < 1) begin m_err = 1; m_code = 3; end
               else if (n == depth) begin m_err = 1; m_code = 2; end
               else begin
                  r = (w == OP_IMM) ? opnd : stk[n-1];
                  stk.push_back(r);
                  m_wa[m_nwr] = base + n; m_wd[m_nwr] = r; m_nwr++; m_result = r;
                  m_cycles += (w == OP_IMM) ? lr + 1 : lm + 1;
                  pc = pc + ((w == OP_IMM) ? 2 : 1);
               end
            end
            OP_JMP: begin m_cycles += lr + 1; pc = opnd & 'hFFFF; end
            OP_JZ: begin
               if (n < 1) begin m_err = 1; m_code = 3; end
               else begin
                  t = stk.pop_back();
                  m_cycles += lr + lm + 1;
                  pc = (t == 0) ? (opnd & 'hFFFF) : pc + 2;
               end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               if (n < 2) begin m_err = 1; m_code = 3; end
               else begin
                  t = stk.pop_back();
                  s = stk.pop_back();
                  case (w)
                     OP_ADD:  r = t + s;
                     OP_SUB:  r = t - s;
                     OP_AND:  r = t & s;
                     OP_OR:   r = t | s;
                     default: r = t ^ s;
                  endcase
                  r = r & mask;
                  stk.push_back(r);
                  m_wa[m_nwr] = base + n - 2; m_wd[m_nwr] = r; m_nwr++; m_result = r;
                  m_cycles += 2 * lm + 1;
                  pc = pc + 1;
               end
            end
            default: begin m_err = 1; m_code = 1; end
         endcase
         pc = pc % 65536;
      end
      m_pc = pc;
      m_sp = base + stk.size();
   endtask

   function automatic bit dut_done(input int sel);
      return (sel != 0) ? (halted_b | error_b) : (halted_a | error_a);
   endfunction

   task automatic run_prog(input string tag, input int sel);
      int edges, wr0, nwr, j;
      for (int i = 0; i < 256; i++) begin
         if (sel != 0) rom_b[i] = prog[i];
         else rom_a[i] = prog[i][15:0];
      end
      if (sel != 0) model_run(32, 2, 4, 1, 1);
      else model_run(16, 256, 0, 2, 2);
      @(negedge clk);
      if (sel != 0) rst_b = 1'b1; else rst_a = 1'b1;
      repeat (3) @(negedge clk);
      wr0 = (sel != 0) ? wr_idx_b : wr_idx_a;
      if (sel != 0) rst_b = 1'b0; else rst_a = 1'b0;
      edges = 0;
      while (!dut_done(sel) && edges < 3000) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check_eq({tag, "_cycles"}, 32'(edges), 32'(m_cycles));
      repeat (4) @(negedge clk);
      nwr = ((sel != 0) ? wr_idx_b : wr_idx_a) - wr0;
      check_eq({tag, "_halted"}, 32'((sel != 0) ? halted_b : halted_a), 32'(m_halt));
      check_eq({tag, "_error"}, 32'((sel != 0) ? error_b : error_a), 32'(m_err));
      check_eq({tag, "_code"}, 32'((sel != 0) ? err_code_b : err_code_a), 32'(m_code));
      check_eq({tag, "_pc"}, 32'((sel != 0) ? pc_b : pc_a), 32'(m_pc));
      check_eq({tag, "_sp"}, 32'((sel != 0) ? sp_b : sp_a), 32'(m_sp));
      check_eq({tag, "_result"}, (sel != 0) ? result_b : 32'(result_a), m_result);
      check_eq({tag, "_nwr"}, 32'(nwr), 32'(m_nwr));
      for (int i = 0; i < nwr && i < m_nwr; i++) begin
         j = (wr0 + i) % 1024;
         check_eq({tag, "_waddr"}, (sel != 0) ? 32'(wa_b[j]) : 32'(wa_a[j]), m_wa[i]);
         check_eq({tag, "_wdata"}, (sel != 0) ? wd_b[j] : 32'(wd_a[j]), m_wd[i]);
      end
   endtask

   task automatic gen_random(input int sel);
      int tbl [13] = '{OP_IMM, OP_IMM, OP_IMM, OP_DUP, OP_DROP, OP_ADD, OP_SUB,
                       OP_AND, OP_OR, OP_XOR, OP_JMP, OP_JZ, OP_NOP};
      int ops [16];
      int addr [17];
      int k, d, pc, op;
      logic [31:0] mask;
      mask = (sel != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      k = $urandom_range(12, 3);
      d = 0;
      for (int i = 0; i < k; i++) begin
         op = tbl[$urandom_range(12, 0)];
         if ($urandom_range(39, 0) == 0) op = OP_ILL;
         else if (d < 2 && !(op inside {OP_IMM, OP_NOP, OP_JMP}) && $urandom_range(3, 0) != 0)
            op = OP_IMM;
         if (op inside {OP_IMM, OP_DUP}) d++;
         else if (op inside {OP_DROP, OP_JZ, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR} && d > 0) d--;
         ops[i] = op;
      end
      pc = 0;
      for (int i = 0; i < k; i++) begin
         addr[i] = pc;
         pc += (ops[i] inside {OP_IMM, OP_JMP, OP_JZ}) ? 2 : 1;
      end
      addr[k] = pc;
      clear_prog();
      for (int i = 0; i < k; i++) begin
         prog[addr[i]] = ops[i];
         if (ops[i] == OP_IMM)
            prog[addr[i] + 1] = ($urandom_range(3, 0) == 0) ? 32'h0 : ($urandom() & mask);
         else if (ops[i] inside {OP_JMP, OP_JZ})
            prog[addr[i] + 1] = addr[$urandom_range(k, i + 1)];
      end
      prog[addr[k]] = OP_HALT;
   endtask

   task automatic prog_imm_imm_op(input int v1, input int v2, input int op);
      clear_prog();
      prog[0] = OP_IMM; prog[1] = v1; prog[2] = OP_IMM; prog[3] = v2;
      prog[4] = op; prog[5] = OP_HALT;
   endtask

   initial begin
      bit seen;
      int wr0;
      logic [31:0] exp_logic [3] = '{32'h0000, 32'h0FFF, 32'h0FFF};
      int logic_ops [3] = '{OP_AND, OP_OR, OP_XOR};

      repeat (2) @(negedge clk);
      check_eq("rst_pc", 32'(pc_a), 0);
      check_eq("rst_sp_b", 32'(sp_b), 4);
      check_eq("rst_flags", 32'({halted_a, error_a, err_code_a, ram_wren_a}), 0);
      check_eq("rst_ram", 32'({ram_addr_a, ram_data_a}), 0);

      prog_imm_imm_op(5, 3, OP_SUB);
      run_prog("t1", 0);
      check_eq("t1_sub_const", 32'(wd_a[(wr_idx_a - 1) % 1024]), 32'hFFFE);
      check_eq("t1_addr_const", 32'(wa_a[(wr_idx_a - 1) % 1024]), 32'h0);

      for (int v = 0; v < 3; v++) begin
         prog_imm_imm_op('h00F0, 'h0F0F, logic_ops[v]);
         run_prog("t2", 0);
         check_eq("t2_const", 32'(result_a), exp_logic[v]);
      end

      for (int v = 0; v < 2; v++) begin
         clear_prog();
         prog[0] = OP_IMM; prog[1] = v; prog[2] = OP_JZ; prog[3] = 7;
         prog[4] = OP_HALT; prog[7] = OP_HALT;
         run_prog("t3", 0);
         check_eq("t3_pc_const", 32'(pc_a), (v == 0) ? 32'd7 : 32'd4);
      end

      clear_prog();
      prog[0] = OP_IMM; prog[1] = 1; prog[2] = OP_IMM; prog[3] = 2;
      prog[4] = OP_IMM; prog[5] = 3; prog[6] = OP_HALT;
      run_prog("t4", 1);
      check_eq("t4_code_const", 32'(err_code_b), 2);

      clear_prog(); prog[0] = OP_ADD;
      run_prog("t5_uf", 0);
      check_eq("t5_uf_const", 32'(err_code_a), 3);
      clear_prog(); prog[0] = OP_ILL;
      run_prog("t5_ill", 0);
      check_eq("t5_ill_const", 32'(err_code_a), 1);

      clear_prog(); prog[0] = OP_IMM; prog[1] = 5; prog[2] = OP_HALT;
      for (int i = 0; i < 256; i++) rom_a[i] = prog[i][15:0];
      @(negedge clk); rst_a = 1'b1;
      repeat (3) @(negedge clk); rst_a = 1'b0;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = ram_wren_a;
      end
      check_eq("t6_wren_seen", 32'(seen), 1);
      wr0 = wr_idx_a;
      rst_a = 1'b1;
      #1;
      check_eq("t6_wren_drop", 32'(ram_wren_a), 0);
      check_eq("t6_pc_sp", 32'({pc_a, sp_a}), 0);
      check_eq("t6_result", 32'(result_a), 0);
      check_eq("t6_ram", 32'({ram_addr_a, ram_data_a}), 0);
      check_eq("t6_rom_addr", 32'(rom_addr_a), 0);
      check_eq("t6_flags", 32'({halted_a, error_a, err_code_a}), 0);
      @(posedge clk); #1;
      check_eq("t6_no_write", 32'(wr_idx_a - wr0), 0);
      run_prog("t6_restart", 0);

      prog_imm_imm_op(5, 3, OP_SUB);
      run_prog("t6_b", 1);
      check_eq("t6_b_const", result_b, 32'hFFFF_FFFE);

      for (int r = 0; r < 20; r++) begin
         gen_random(0);
         run_prog("rnd_a", 0);
      end
      for (int r = 0; r < 12; r++) begin
         gen_random(1);
         run_prog("rnd_b", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
